control_multiciclo: RTL and testbench

Multicycle main control unit for the RISC-V datapath. It replaces the single-cycle opcode decoder with a Moore state machine. The machine sequences each RV32I instruction through fetch, decode, execute, memory and write-back steps over a shared ALU and a unified memory. Memory accesses use a ready handshake so wait-state memories can be attached. The block drives every datapath mux select and write enable, and signals instruction retirement to the performance counters.

---
 rtl/control_pkg.sv | 69 ++++++
 rtl/control_opc_class.sv | 25 ++
 rtl/control_multiciclo.sv | 206 ++++++++++++++++++++
 tb/tb_control_multiciclo.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared definitions for the multicycle control unit: FSM states, opcode
// constants, instruction classes and datapath select encodings.
// Optional feature macro: CONTROL_ILLEGAL_TRAP_EN (adds the TRAP state).
package control_pkg;

    localparam int OPC_W = 7;

    // RV32I major opcodes
    localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_I      = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

    // ALU control class
    localparam logic [1:0] ALUOP_R   = 2'b00;
    localparam logic [1:0] ALUOP_I   = 2'b01;
    localparam logic [1:0] ALUOP_ADD = 2'b10;
    localparam logic [1:0] ALUOP_BR  = 2'b11;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Upper-immediate operand select
    localparam logic [1:0] UPPER_AUIPC  = 2'b01;
    localparam logic [1:0] UPPER_NORMAL = 2'b10;

    // Control FSM states
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_UPPER  = 4'd10,
        S_ALUWB  = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    // Instruction classes produced by the opcode decoder
    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_R      = 3'd3,
        CLS_I      = 3'd4,
        CLS_BRANCH = 3'd5,
        CLS_JUMP   = 3'd6,
        CLS_UPPER  = 3'd7
    } opc_class_t;

endpackage

// File: rtl/control_opc_class.sv
// Combinational opcode to instruction-class decoder used by the DECODE
// transition and by the MEMADR load/store split.
import control_pkg::*;

module control_opc_class (
    input  logic [OPC_W-1:0] opcode,
    output opc_class_t       cls
);

    // Map each supported opcode onto its execution class
    always_comb begin
        cls = CLS_NONE;
        case (opcode)
            OPC_LOAD:            cls = CLS_LOAD;
            OPC_STORE:           cls = CLS_STORE;
            OPC_R:               cls = CLS_R;
            OPC_I:               cls = CLS_I;
            OPC_BRANCH:          cls = CLS_BRANCH;
            OPC_JAL, OPC_JALR:   cls = CLS_JUMP;
            OPC_LUI, OPC_AUIPC:  cls = CLS_UPPER;
            default:             cls = CLS_NONE;
        endcase
    end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle Moore control unit for the RV32I datapath. Sequences fetch,
// decode, execute, memory and write-back over a shared ALU and a unified
// memory with a ready handshake.
// Optional feature macro: CONTROL_ILLEGAL_TRAP_EN -- unknown opcodes enter a
// sticky TRAP state and raise ILLEGAL instead of retiring as a NOP.
//
// Memory handshake: MEMREAD/MEMWRITE (with ADRSRC) form a request that is held
// stable every cycle until the memory answers with MEM_READY=1; the access
// completes in the cycle where request and MEM_READY are both high, and the
// FSM leaves the requesting state on the following edge.
import control_pkg::*;

module control_multiciclo #(
    parameter int TAM_INS      = 7,
    parameter int TAM_ALUOP    = 2,
    parameter int TAM_AUIPCLUI = 2,
    parameter int TAM_SRC      = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [TAM_INS-1:0]      OPCODE,
    input  logic                    MEM_READY,
    output logic                    IRWRITE,
    output logic                    PCWRITE,
    output logic                    BRANCH,
    output logic                    ADRSRC,
    output logic                    MEMREAD,
    output logic                    MEMWRITE,
    output logic                    MEMTOREG,
    output logic                    REGWRITE,
    output logic [TAM_SRC-1:0]      ALUSRCA,
    output logic [TAM_SRC-1:0]      ALUSRCB,
    output logic [TAM_ALUOP-1:0]    ALUOP,
    output logic [TAM_AUIPCLUI-1:0] AUIPCLUI,
    output logic                    RETIRE,
`ifdef CONTROL_ILLEGAL_TRAP_EN
    output logic                    ILLEGAL,
`endif
    output state_t                  dbg_state
);

    state_t     state;
    state_t     state_next;
    opc_class_t cls;

    control_opc_class u_opc_class (
        .opcode (OPCODE[OPC_W-1:0]),
        .cls    (cls)
    );

    assign dbg_state = state;

    // State register; reset takes effect on the clock edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (MEM_READY) state_next = S_DECODE;
            S_DECODE: begin
                case (cls)
                    CLS_LOAD, CLS_STORE: state_next = S_MEMADR;
                    CLS_R:               state_next = S_EXEC_R;
                    CLS_I:               state_next = S_EXEC_I;
                    CLS_BRANCH:          state_next = S_BRANCH;
                    CLS_JUMP:            state_next = S_JUMP;
                    CLS_UPPER:           state_next = S_UPPER;
`ifdef CONTROL_ILLEGAL_TRAP_EN
                    default:             state_next = S_TRAP;
`else
                    default:             state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: state_next = (cls == CLS_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (MEM_READY) state_next = S_MEMWB;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  if (MEM_READY) state_next = S_FETCH;
            S_EXEC_R: state_next = S_ALUWB;
            S_EXEC_I: state_next = S_ALUWB;
            S_BRANCH: state_next = S_FETCH;
            S_JUMP:   state_next = S_ALUWB;
            S_UPPER:  state_next = S_ALUWB;
            S_ALUWB:  state_next = S_FETCH;
`ifdef CONTROL_ILLEGAL_TRAP_EN
            S_TRAP:   state_next = S_TRAP;
`endif
            default:  state_next = S_FETCH;
        endcase
    end

    // Output decode; reset forces every enable and select to its idle value
    always_comb begin
        IRWRITE  = 1'b0;
        PCWRITE  = 1'b0;
        BRANCH   = 1'b0;
        ADRSRC   = 1'b0;
        MEMREAD  = 1'b0;
        MEMWRITE = 1'b0;
        MEMTOREG = 1'b0;
        REGWRITE = 1'b0;
        ALUSRCA  = SRCA_PC;
        ALUSRCB  = SRCB_RS2;
        ALUOP    = ALUOP_R;
        AUIPCLUI = UPPER_NORMAL;
        RETIRE   = 1'b0;
`ifdef CONTROL_ILLEGAL_TRAP_EN
        ILLEGAL  = 1'b0;
`endif
        if (!RST) begin
            case (state)
                S_FETCH: begin
                    MEMREAD = 1'b1;
                    ALUSRCA = SRCA_PC;
                    ALUSRCB = SRCB_FOUR;
                    ALUOP   = ALUOP_ADD;
                    IRWRITE = MEM_READY;
                    PCWRITE = MEM_READY;
                end
                S_DECODE: begin
                    // Branch/JAL target precomputed into the ALU result register
                    ALUSRCA = SRCA_OLDPC;
                    ALUSRCB = SRCB_IMM;
                    ALUOP   = ALUOP_ADD;
`ifndef CONTROL_ILLEGAL_TRAP_EN
                    RETIRE  = (cls == CLS_NONE);
`endif
                end
                S_MEMADR: begin
                    ALUSRCA = SRCA_RS1;
                    ALUSRCB = SRCB_IMM;
                    ALUOP   = ALUOP_ADD;
                end
                S_MEMRD: begin
                    ADRSRC  = 1'b1;
                    MEMREAD = 1'b1;
                end
                S_MEMWB: begin
                    MEMTOREG = 1'b1;
                    REGWRITE = 1'b1;
                    RETIRE   = 1'b1;
                end
                S_MEMWR: begin
                    ADRSRC   = 1'b1;
                    MEMWRITE = 1'b1;
                    RETIRE   = MEM_READY;
                end
                S_EXEC_R: begin
                    ALUSRCA = SRCA_RS1;
                    ALUSRCB = SRCB_RS2;
                    ALUOP   = ALUOP_R;
                end
                S_EXEC_I: begin
                    ALUSRCA = SRCA_RS1;
                    ALUSRCB = SRCB_IMM;
                    ALUOP   = ALUOP_I;
                end
                S_BRANCH: begin
                    ALUSRCA = SRCA_RS1;
                    ALUSRCB = SRCB_RS2;
                    ALUOP   = ALUOP_BR;
                    BRANCH  = 1'b1;
                    RETIRE  = 1'b1;
                end
                S_JUMP: begin
                    // JAL (bit 3 set) keeps old PC; JALR takes rs1 as operand A
                    PCWRITE = 1'b1;
                    ALUSRCA = OPCODE[3] ? SRCA_OLDPC : SRCA_RS1;
                    ALUSRCB = SRCB_FOUR;
                    ALUOP   = ALUOP_ADD;
                end
                S_UPPER: begin
                    // AUIPC (bit 5 clear) adds to old PC; LUI adds to zero
                    ALUSRCB = SRCB_IMM;
                    ALUOP   = ALUOP_I;
                    if (OPCODE[5]) begin
                        ALUSRCA = SRCA_ZERO;
                    end else begin
                        ALUSRCA  = SRCA_OLDPC;
                        AUIPCLUI = UPPER_AUIPC;
                    end
                end
                S_ALUWB: begin
                    MEMTOREG = 1'b0;
                    REGWRITE = 1'b1;
                    RETIRE   = 1'b1;
                end
`ifdef CONTROL_ILLEGAL_TRAP_EN
                S_TRAP: begin
                    ILLEGAL = 1'b1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed bench for control_multiciclo: steps instructions cycle by cycle
// and checks state plus every control output against hand-written vectors.
import control_pkg::*;

module tb_control_multiciclo;

    logic       CLK;
    logic       RST;
    logic [6:0] OPCODE;
    logic       MEM_READY;
    logic       IRWRITE, PCWRITE, BRANCH, ADRSRC, MEMREAD, MEMWRITE;
    logic       MEMTOREG, REGWRITE, RETIRE;
    logic [1:0] ALUSRCA, ALUSRCB, ALUOP, AUIPCLUI;
`ifdef CONTROL_ILLEGAL_TRAP_EN
    logic       ILLEGAL;
`endif
    state_t     dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    control_multiciclo dut (
        .CLK       (CLK),
        .RST       (RST),
        .OPCODE    (OPCODE),
        .MEM_READY (MEM_READY),
        .IRWRITE   (IRWRITE),
        .PCWRITE   (PCWRITE),
        .BRANCH    (BRANCH),
        .ADRSRC    (ADRSRC),
        .MEMREAD   (MEMREAD),
        .MEMWRITE  (MEMWRITE),
        .MEMTOREG  (MEMTOREG),
        .REGWRITE  (REGWRITE),
        .ALUSRCA   (ALUSRCA),
        .ALUSRCB   (ALUSRCB),
        .ALUOP     (ALUOP),
        .AUIPCLUI  (AUIPCLUI),
        .RETIRE    (RETIRE),
`ifdef CONTROL_ILLEGAL_TRAP_EN
        .ILLEGAL   (ILLEGAL),
`endif
        .dbg_state (dbg_state)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Output vector layout:
    // {IRW,PCW,BR,ADR,MR,MW,MTR,RW, SRCA[1:0],SRCB[1:0],ALUOP[1:0],AUIPCLUI[1:0], RET}
    localparam logic [16:0] V_RESET      = 17'b0_0_0_0_0_0_0_0_00_00_00_10_0;
    localparam logic [16:0] V_FETCH_RDY  = 17'b1_1_0_0_1_0_0_0_00_10_10_10_0;
    localparam logic [16:0] V_FETCH_WAIT = 17'b0_0_0_0_1_0_0_0_00_10_10_10_0;
    localparam logic [16:0] V_DECODE     = 17'b0_0_0_0_0_0_0_0_01_01_10_10_0;
    localparam logic [16:0] V_DECODE_NOP = 17'b0_0_0_0_0_0_0_0_01_01_10_10_1;
    localparam logic [16:0] V_MEMADR     = 17'b0_0_0_0_0_0_0_0_10_01_10_10_0;
    localparam logic [16:0] V_MEMRD      = 17'b0_0_0_1_1_0_0_0_00_00_00_10_0;
    localparam logic [16:0] V_MEMWB      = 17'b0_0_0_0_0_0_1_1_00_00_00_10_1;
    localparam logic [16:0] V_MEMWR_RDY  = 17'b0_0_0_1_0_1_0_0_00_00_00_10_1;
    localparam logic [16:0] V_MEMWR_WAIT = 17'b0_0_0_1_0_1_0_0_00_00_00_10_0;
    localparam logic [16:0] V_EXEC_R     = 17'b0_0_0_0_0_0_0_0_10_00_00_10_0;
    localparam logic [16:0] V_EXEC_I     = 17'b0_0_0_0_0_0_0_0_10_01_01_10_0;
    localparam logic [16:0] V_BRANCH     = 17'b0_0_1_0_0_0_0_0_10_00_11_10_1;
    localparam logic [16:0] V_JAL        = 17'b0_1_0_0_0_0_0_0_01_10_10_10_0;
    localparam logic [16:0] V_JALR       = 17'b0_1_0_0_0_0_0_0_10_10_10_10_0;
    localparam logic [16:0] V_LUI        = 17'b0_0_0_0_0_0_0_0_11_01_01_10_0;
    localparam logic [16:0] V_AUIPC      = 17'b0_0_0_0_0_0_0_0_01_01_01_01_0;
    localparam logic [16:0] V_ALUWB      = 17'b0_0_0_0_0_0_0_1_00_00_00_10_1;
    localparam logic [16:0] V_IDLE       = 17'b0_0_0_0_0_0_0_0_00_00_00_10_0;

    function automatic logic [16:0] obs_vec();
        return {IRWRITE, PCWRITE, BRANCH, ADRSRC, MEMREAD, MEMWRITE, MEMTOREG,
                REGWRITE, ALUSRCA, ALUSRCB, ALUOP, AUIPCLUI, RETIRE};
    endfunction

    // Check state and outputs of the current cycle, then advance one cycle
    task automatic cyc(input logic rdy, input state_t exp_st,
                       input logic [16:0] exp_v, input string tag);
        MEM_READY = rdy;
        #1;
        n_total++;
        assert (dbg_state === exp_st) n_pass++;
        else $error("FAIL %s state: observed %0d expected %0d", tag, dbg_state, exp_st);
        n_total++;
        assert (obs_vec() === exp_v) n_pass++;
        else $error("FAIL %s outputs: observed %b expected %b", tag, obs_vec(), exp_v);
        @(negedge CLK);
    endtask

    initial begin
        // Reset for two edges
        RST       = 1'b1;
        MEM_READY = 1'b1;
        OPCODE    = OPC_R;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        cyc(1'b1, S_FETCH, V_RESET, "reset");

        // R-type, 4 cycles
        RST = 1'b0;
        cyc(1'b1, S_FETCH,  V_FETCH_RDY, "r_fetch");
        cyc(1'b1, S_DECODE, V_DECODE,    "r_decode");
        cyc(1'b1, S_EXEC_R, V_EXEC_R,    "r_exec");
        cyc(1'b1, S_ALUWB,  V_ALUWB,     "r_wb");

        // Load with three wait cycles in MEMRD, 8 cycles
        OPCODE = OPC_LOAD;
        cyc(1'b1, S_FETCH,  V_FETCH_RDY, "ld_fetch");
        cyc(1'b1, S_DECODE, V_DECODE,    "ld_decode");
        cyc(1'b1, S_MEMADR, V_MEMADR,    "ld_memadr");
        cyc(1'b0, S_MEMRD,  V_MEMRD,     "ld_memrd_w1");
        cyc(1'b0, S_MEMRD,  V_MEMRD,     "ld_memrd_w2");
        cyc(1'b0, S_MEMRD,  V_MEMRD,     "ld_memrd_w3");
        cyc(1'b1, S_MEMRD,  V_MEMRD,     "ld_memrd_rdy");
        cyc(1'b1, S_MEMWB,  V_MEMWB,     "ld_memwb");

        // Store, zero wait, 4 cycles
        OPCODE = OPC_STORE;
        cyc(1'b1, S_FETCH,  V_FETCH_RDY, "st_fetch");
        cyc(1'b1, S_DECODE, V_DECODE,    "st_decode");
        cyc(1'b1, S_MEMADR, V_MEMADR,    "st_memadr");
        cyc(1'b1, S_MEMWR,  V_MEMWR_RDY, "st_memwr");

        // Store with a fetch wait and a write wait
        cyc(1'b0, S_FETCH,  V_FETCH_WAIT, "st2_fetch_w");
        cyc(1'b1, S_FETCH,  V_FETCH_RDY,  "st2_fetch");
        cyc(1'b1, S_DECODE, V_DECODE,     "st2_decode");
        cyc(1'b1, S_MEMADR, V_MEMADR,     "st2_memadr");
        cyc(1'b0, S_MEMWR,  V_MEMWR_WAIT, "st2_memwr_w");
        cyc(1'b1, S_MEMWR,  V_MEMWR_RDY,  "st2_memwr");

        // Branch, 3 cycles then back in FETCH
        OPCODE = OPC_BRANCH;
        cyc(1'b1, S_FETCH,  V_FETCH_RDY, "br_fetch");
        cyc(1'b1, S_DECODE, V_DECODE,    "br_decode");
        cyc(1'b1, S_BRANCH, V_BRANCH,    "br_exec");

        // I-type
        OPCODE = OPC_I;
        cyc(1'b1, S_FETCH,  V_FETCH_RDY, "i_fetch");
        cyc(1'b1, S_DECODE, V_DECODE,    "i_decode");
        cyc(1'b1, S_EXEC_I, V_EXEC_I,    "i_exec");
        cyc(1'b1, S_ALUWB,  V_ALUWB,     "i_wb");

        // JAL
        OPCODE = OPC_JAL;
        cyc(1'b1, S_FETCH,  V_FETCH_RDY, "jal_fetch");
        cyc(1'b1, S_DECODE, V_DECODE,    "jal_decode");
        cyc(1'b1, S_JUMP,   V_JAL,       "jal_jump");
        cyc(1'b1, S_ALUWB,  V_ALUWB,     "jal_wb");

        // JALR
        OPCODE = OPC_JALR;
        cyc(1'b1, S_FETCH,  V_FETCH_RDY, "jalr_fetch");
        cyc(1'b1, S_DECODE, V_DECODE,    "jalr_decode");
        cyc(1'b1, S_JUMP,   V_JALR,      "jalr_jump");
        cyc(1'b1, S_ALUWB,  V_ALUWB,     "jalr_wb");

        // AUIPC
        OPCODE = OPC_AUIPC;
        cyc(1'b1, S_FETCH,  V_FETCH_RDY, "auipc_fetch");
        cyc(1'b1, S_DECODE, V_DECODE,    "auipc_decode");
        cyc(1'b1, S_UPPER,  V_AUIPC,     "auipc_upper");
        cyc(1'b1, S_ALUWB,  V_ALUWB,     "auipc_wb");

        // LUI
        OPCODE = OPC_LUI;
        cyc(1'b1, S_FETCH,  V_FETCH_RDY, "lui_fetch");
        cyc(1'b1, S_DECODE, V_DECODE,    "lui_decode");
        cyc(1'b1, S_UPPER,  V_LUI,       "lui_upper");
        cyc(1'b1, S_ALUWB,  V_ALUWB,     "lui_wb");

        // Reset landing in MEMWR aborts the store with no retire
        OPCODE = OPC_STORE;
        cyc(1'b1, S_FETCH,  V_FETCH_RDY, "abort_fetch");
        cyc(1'b1, S_DECODE, V_DECODE,    "abort_decode");
        cyc(1'b1, S_MEMADR, V_MEMADR,    "abort_memadr");
        RST = 1'b1;
        cyc(1'b1, S_MEMWR,  V_RESET,     "abort_memwr");
        cyc(1'b1, S_FETCH,  V_RESET,     "abort_reset");
        RST = 1'b0;

        // Unknown opcode
        OPCODE = 7'b1111111;
        cyc(1'b1, S_FETCH,  V_FETCH_RDY,  "bad_fetch");
`ifdef CONTROL_ILLEGAL_TRAP_EN
        cyc(1'b1, S_DECODE, V_DECODE,     "bad_decode");
        for (int i = 0; i < 3; i++) begin
            n_total++;
            #1;
            assert (ILLEGAL === 1'b1) n_pass++;
            else $error("FAIL trap_illegal: observed %b expected 1", ILLEGAL);
            cyc(1'b1, S_TRAP, V_IDLE, "trap_hold");
        end
        RST = 1'b1;
        cyc(1'b1, S_TRAP,   V_RESET,      "trap_reset");
        RST = 1'b0;
        n_total++;
        #1;
        assert (ILLEGAL === 1'b0) n_pass++;
        else $error("FAIL trap_cleared: observed %b expected 0", ILLEGAL);
        cyc(1'b1, S_FETCH,  V_FETCH_RDY,  "trap_refetch");
`else
        cyc(1'b1, S_DECODE, V_DECODE_NOP, "bad_decode");
        cyc(1'b1, S_FETCH,  V_FETCH_RDY,  "bad_next_fetch");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
